// File: rtl/piso_tx.sv
// piso_tx: valid/ready word in, LSB-first bit-serial out with enable and last strobes.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sout,
    output logic              sout_en,
    output logic              sout_last,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     div_q, div_d;
    logic              in_ready_q, in_ready_d;
    logic              sout_q, sout_d;
    logic              sout_en_q, sout_en_d;
    logic              sout_last_q, sout_last_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = SHIFT;
                    shift_d = in_data;
                    cnt_d   = '0;
                    div_d   = '0;
`ifdef PISO_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (div_q == DIV_MAX) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
`ifdef PISO_TX_PARITY_EN
                    if (cnt_q == LAST_BIT) state_d = PAR;
`else
                    if (cnt_q == LAST_BIT) state_d = IDLE;
`endif
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef PISO_TX_PARITY_EN
            PAR: begin
                if (div_q == DIV_MAX) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Outputs are registered: derive them from the state being entered.
        in_ready_d = state_d == IDLE;
        busy_d     = state_d != IDLE;
        sout_en_d  = state_d != IDLE;
`ifdef PISO_TX_PARITY_EN
        sout_d      = state_d == PAR ? par_d : (state_d == SHIFT && shift_d[0]);
        sout_last_d = state_d == PAR;
`else
        sout_d      = state_d == SHIFT && shift_d[0];
        sout_last_d = state_d == SHIFT && cnt_d == LAST_BIT;
`endif
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            in_ready_q  <= 1'b0;
            sout_q      <= 1'b0;
            sout_en_q   <= 1'b0;
            sout_last_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            in_ready_q  <= in_ready_d;
            sout_q      <= sout_d;
            sout_en_q   <= sout_en_d;
            sout_last_q <= sout_last_d;
            busy_q      <= busy_d;
`ifdef PISO_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign sout      = sout_q;
    assign sout_en   = sout_en_q;
    assign sout_last = sout_last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized frames on a CLK_DIV=1 and a CLK_DIV=3 transmitter against a bit-index model.
module tb_piso_tx;
`ifdef PISO_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 8 + PB;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] vld;
    logic [7:0] din [2];
    logic [1:0] rdy, so, en, lst, bsy;
    int         total = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    piso_tx #(.DATA_W(8), .CLK_DIV(1)) u_div1 (
        .aclk(clk), .arst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0]),
        .sout(so[0]), .sout_en(en[0]), .sout_last(lst[0]), .busy(bsy[0])
    );

    piso_tx #(.DATA_W(8), .CLK_DIV(3)) u_div3 (
        .aclk(clk), .arst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1]),
        .sout(so[1]), .sout_en(en[1]), .sout_last(lst[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected line value for bit slot k of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        return k < 8 ? w[k] : ^w;
    endfunction

    task automatic send(input int s, input logic [7:0] w, input bit hold, input logic [7:0] nxt,
                        input int abort_bit, output int waited);
        int div = s == 1 ? 3 : 1;
        waited = 0;
        while (!rdy[s] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rdy_wait", 32'(rdy[s]), 1);
        vld[s] = 1'b1;
        din[s] = w;
        @(negedge clk);
        vld[s] = hold;
        din[s] = 8'($urandom);
        for (int c = 0; c < NB * div; c++) begin
            int k = c / div;
            if (abort_bit >= 0 && c == abort_bit * div) begin
                rst = 1'b1;
                #1;
                check("abort_sout", 32'(so[s]), 0);
                check("abort_en", 32'(en[s]), 0);
                check("abort_busy", 32'(bsy[s]), 0);
                vld[s] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            check("sout", 32'(so[s]), 32'(exp_bit(w, k)));
            check("sout_en", 32'(en[s]), 1);
            check("sout_last", 32'(lst[s]), 32'(k == NB - 1));
            check("busy", 32'(bsy[s]), 1);
            check("rdy_mid", 32'(rdy[s]), 0);
            din[s] = c == NB * div - 1 ? nxt : 8'($urandom);
            @(negedge clk);
        end
        check("gap_en", 32'(en[s]), 0);
        check("gap_busy", 32'(bsy[s]), 0);
        check("gap_rdy", 32'(rdy[s]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int         wt;
        int         s;
        bit         hold;
        logic [7:0] w8, nx;
        rst = 1'b1;
        vld = 2'b11;
        din[0] = 8'hA5;
        din[1] = 8'h5A;
        repeat (5) begin
            @(negedge clk);
            check("rst_rdy", 32'(rdy), 0);
            check("rst_sout", 32'(so), 0);
            check("rst_en", 32'(en), 0);
            check("rst_busy", 32'(bsy), 0);
        end
        rst = 1'b0;
        vld = 2'b00;
        @(negedge clk);
        check("rdy_after_rst", 32'(rdy), 3);

        send(0, 8'hA5, 1'b0, 8'h00, -1, wt);
        send(1, 8'h01, 1'b0, 8'h00, -1, wt);
        send(0, 8'h3C, 1'b1, 8'hC3, -1, wt);
        send(0, 8'hC3, 1'b0, 8'h00, -1, wt);
        check("b2b_gap0", 32'(wt), 0);
        send(1, 8'h3C, 1'b1, 8'hC3, -1, wt);
        send(1, 8'hC3, 1'b0, 8'h00, -1, wt);
        check("b2b_gap1", 32'(wt), 0);
        send(0, 8'hFF, 1'b0, 8'h00, 4, wt);
        send(0, 8'h0F, 1'b0, 8'h00, -1, wt);
        send(1, 8'hFF, 1'b0, 8'h00, 4, wt);
        send(1, 8'h0F, 1'b0, 8'h00, -1, wt);
        send(0, 8'h07, 1'b0, 8'h00, -1, wt);
        send(0, 8'h03, 1'b0, 8'h00, -1, wt);

        s = 0;
        hold = 1'b0;
        w8 = 8'($urandom);
        for (int i = 0; i < 30; i++) begin
            if (!hold) s = int'($urandom_range(0, 1));
            hold = 1'($urandom);
            nx = 8'($urandom);
            send(s, w8, hold, nx, -1, wt);
            w8 = hold ? nx : 8'($urandom);
        end
        vld = 2'b00;
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
